// File: rtl/renderer_pkg.sv
// Shared encodings for the renderer block family: fill modes and the
// rectangle-fill sequencer states.
package renderer_pkg;

    typedef enum logic {
        MODE_OPAQUE = 1'b0,
        MODE_XOR    = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LINE_START,
        ST_READ,
        ST_READ_WAIT,
        ST_WRITE,
        ST_WRITE_WAIT,
        ST_NEXT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/renderer_pixel_merge.sv
// Per-word slot mask for an inclusive pixel span, merged with read-back data
// (opaque replace or XOR). Slot 0 sits in the most significant pixel field.
module renderer_pixel_merge
    import renderer_pkg::*;
#(
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned PIX_PER_WORD = 2,
    parameter int unsigned X_W          = 10,
    localparam int unsigned PIX_W       = 3 * COLOR_W,
    localparam int unsigned WORD_W      = PIX_PER_WORD * PIX_W,
    localparam int unsigned LOG_PPW     = $clog2(PIX_PER_WORD),
    localparam int unsigned COL_W       = X_W - LOG_PPW
) (
    input  logic [COL_W-1:0]        col_i,
    input  logic [X_W-1:0]          x1_i,
    input  logic [X_W-1:0]          x2_i,
    input  logic [PIX_W-1:0]        color_i,
    input  mode_e                   mode_i,
    input  logic [WORD_W-1:0]       rdata_i,
    output logic [PIX_PER_WORD-1:0] mask_o,
    output logic [WORD_W-1:0]       wdata_o
);

    logic [X_W-1:0] px;

    always_comb begin
        mask_o  = '0;
        wdata_o = rdata_i;
        px      = '0;
        for (int unsigned s = 0; s < PIX_PER_WORD; s++) begin
            px = (X_W'(col_i) << LOG_PPW) | X_W'(s);
            if (px >= x1_i && px <= x2_i) begin
                mask_o[s] = 1'b1;
                if (mode_i == MODE_XOR)
                    wdata_o[WORD_W-1-s*PIX_W -: PIX_W] = rdata_i[WORD_W-1-s*PIX_W -: PIX_W] ^ color_i;
                else
                    wdata_o[WORD_W-1-s*PIX_W -: PIX_W] = color_i;
            end
        end
    end

endmodule

// File: rtl/renderer_rect_fill_multi.sv
// Rectangle fill over packed-pixel VRAM: walks lines and word columns,
// doing read-modify-write only where a word is partially covered or XORed.
module renderer_rect_fill_multi
    import renderer_pkg::*;
#(
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned PIX_PER_WORD = 2,
    parameter int unsigned X_W          = 10,
    parameter int unsigned Y_W          = 10,
    localparam int unsigned PIX_W       = 3 * COLOR_W,
    localparam int unsigned WORD_W      = PIX_PER_WORD * PIX_W,
    localparam int unsigned LOG_PPW     = $clog2(PIX_PER_WORD),
    localparam int unsigned COL_W       = X_W - LOG_PPW,
    localparam int unsigned ADDR_W      = 1 + Y_W + COL_W
) (
    input  logic              i_master_clk,
    input  logic              i_reset,
    input  logic [X_W-1:0]    i_cmd_x1,
    input  logic [X_W-1:0]    i_cmd_x2,
    input  logic [Y_W-1:0]    i_cmd_y1,
    input  logic [Y_W-1:0]    i_cmd_y2,
    input  logic [PIX_W-1:0]  i_cmd_color,
    input  logic              i_cmd_mode,
    input  logic              i_process_start,
    output logic              o_process_done,
    output logic              o_busy,
    input  logic              i_buffer_bank,
    output logic [ADDR_W-1:0] o_vram_read_address,
    output logic [ADDR_W-1:0] o_vram_write_address,
    output logic              o_vram_read_request,
    input  logic [WORD_W-1:0] i_vram_read_data,
    input  logic              i_vram_read_data_valid,
    output logic              o_vram_write_request,
    output logic [WORD_W-1:0] o_vram_write_data,
    input  logic              i_vram_write_done
);

    state_e              state_q, state_d;
    logic [X_W-1:0]      x1_q, x1_d, x2_q, x2_d;
    logic [Y_W-1:0]      y1_q, y1_d, y2_q, y2_d;
    logic [PIX_W-1:0]    color_q, color_d;
    mode_e               mode_q, mode_d;
    logic                bank_q, bank_d;
    logic [Y_W-1:0]      line_q, line_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic [COL_W-1:0]        first_col, last_col_idx;
    logic                    last_col, last_line, need_read;
    logic [PIX_PER_WORD-1:0] merge_mask;
    logic [WORD_W-1:0]       merge_rdata, merge_wdata;

    assign first_col    = COL_W'(x1_q >> LOG_PPW);
    assign last_col_idx = COL_W'(x2_q >> LOG_PPW);
    assign last_col     = (col_q == last_col_idx);
    assign last_line    = (line_q == y2_q);
    assign merge_rdata  = (state_q == ST_READ_WAIT) ? i_vram_read_data : '0;
    assign need_read    = (mode_q == MODE_XOR) || (merge_mask != '1);

    // Mask and merge are evaluated for the column about to be accessed (col_d),
    // so NEXT can decide read-vs-write for the column it is stepping onto.
    renderer_pixel_merge #(
        .COLOR_W      (COLOR_W),
        .PIX_PER_WORD (PIX_PER_WORD),
        .X_W          (X_W)
    ) u_merge (
        .col_i   (col_d),
        .x1_i    (x1_q),
        .x2_i    (x2_q),
        .color_i (color_q),
        .mode_i  (mode_q),
        .rdata_i (merge_rdata),
        .mask_o  (merge_mask),
        .wdata_o (merge_wdata)
    );

    always_comb begin
        line_d = line_q;
        col_d  = col_q;
        if (state_q == ST_IDLE && i_process_start) begin
            line_d = i_cmd_y1;
            col_d  = COL_W'(i_cmd_x1 >> LOG_PPW);
        end else if (state_q == ST_NEXT) begin
            if (last_col) begin
                line_d = line_q + 1'b1;
                col_d  = first_col;
            end else begin
                col_d  = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        color_d = color_q;
        mode_d  = mode_q;
        bank_d  = bank_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_process_start) begin
                    x1_d    = i_cmd_x1;
                    x2_d    = i_cmd_x2;
                    y1_d    = i_cmd_y1;
                    y2_d    = i_cmd_y2;
                    color_d = i_cmd_color;
                    mode_d  = mode_e'(i_cmd_mode);
                    bank_d  = i_buffer_bank;
                    state_d = ST_LINE_START;
                end
            end
            ST_LINE_START: begin
                if (x1_q > x2_q || y1_q > y2_q) begin
                    state_d = ST_DONE;
                end else if (need_read) begin
                    state_d = ST_READ;
                end else begin
                    wdata_d = merge_wdata;
                    state_d = ST_WRITE;
                end
            end
            ST_READ:       state_d = ST_READ_WAIT;
            ST_READ_WAIT: begin
                if (i_vram_read_data_valid) begin
                    wdata_d = merge_wdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE:      state_d = ST_WRITE_WAIT;
            ST_WRITE_WAIT: begin
                if (i_vram_write_done)
                    state_d = (last_col && last_line) ? ST_DONE : ST_NEXT;
            end
            ST_NEXT: begin
                if (last_col) begin
                    state_d = ST_LINE_START;
                end else if (need_read) begin
                    state_d = ST_READ;
                end else begin
                    wdata_d = merge_wdata;
                    state_d = ST_WRITE;
                end
            end
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            x1_q    <= '0;
            x2_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            color_q <= '0;
            mode_q  <= MODE_OPAQUE;
            bank_q  <= 1'b0;
            line_q  <= '0;
            col_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            color_q <= color_d;
            mode_q  <= mode_d;
            bank_q  <= bank_d;
            line_q  <= line_d;
            col_q   <= col_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_vram_read_address  = {bank_q, line_q, col_q};
    assign o_vram_write_address = {bank_q, line_q, col_q};
    assign o_vram_write_data    = wdata_q;
    assign o_vram_read_request  = (state_q == ST_READ);
    assign o_vram_write_request = (state_q == ST_WRITE);
    assign o_busy               = (state_q != ST_IDLE);
    assign o_process_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_renderer_rect_fill_multi.sv
// Directed bench for renderer_rect_fill_multi at default parameters with a
// small VRAM responder that logs every request.
module tb_renderer_rect_fill_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cmd_x1, cmd_x2, cmd_y1, cmd_y2;
    logic [11:0] cmd_color;
    logic        cmd_mode, start, done, busy, bank;
    logic [19:0] rd_addr, wr_addr;
    logic        rd_req, rd_valid, wr_req, wr_done;
    logic [23:0] rd_data, wdata;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned done_cnt = 0;
    int unsigned rd_lat = 2;

    logic [19:0] rd_addr_log[$];
    logic [19:0] wr_addr_log[$];
    logic [23:0] wr_data_log[$];
    logic [23:0] rd_data_q[$];
    logic [19:0] exp_a[$];
    logic [23:0] exp_d[$];

    always #5 clk = ~clk;

    renderer_rect_fill_multi #(
        .COLOR_W      (4),
        .PIX_PER_WORD (2),
        .X_W          (10),
        .Y_W          (10)
    ) dut (
        .i_master_clk           (clk),
        .i_reset                (rst),
        .i_cmd_x1               (cmd_x1),
        .i_cmd_x2               (cmd_x2),
        .i_cmd_y1               (cmd_y1),
        .i_cmd_y2               (cmd_y2),
        .i_cmd_color            (cmd_color),
        .i_cmd_mode             (cmd_mode),
        .i_process_start        (start),
        .o_process_done         (done),
        .o_busy                 (busy),
        .i_buffer_bank          (bank),
        .o_vram_read_address    (rd_addr),
        .o_vram_write_address   (wr_addr),
        .o_vram_read_request    (rd_req),
        .i_vram_read_data       (rd_data),
        .i_vram_read_data_valid (rd_valid),
        .o_vram_write_request   (wr_req),
        .o_vram_write_data      (wdata),
        .i_vram_write_done      (wr_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // VRAM responder: valid/done arrive rd_lat / 2 cycles after a request.
    initial begin
        logic [19:0] a;
        logic [23:0] d;
        rd_valid = 1'b0;
        wr_done  = 1'b0;
        rd_data  = '0;
        forever begin
            @(posedge clk); #1;
            rd_valid = 1'b0;
            wr_done  = 1'b0;
            if (rd_req) begin
                rd_addr_log.push_back(rd_addr);
                repeat (rd_lat) @(posedge clk);
                #1;
                if (rd_data_q.size() > 0) rd_data = rd_data_q.pop_front();
                else rd_data = '0;
                rd_valid = 1'b1;
            end else if (wr_req) begin
                a = wr_addr;
                d = wdata;
                wr_addr_log.push_back(a);
                wr_data_log.push_back(d);
                repeat (2) @(posedge clk);
                #1;
                check("wr_stable", 32'(wr_addr == a && wdata == d), 32'd1);
                wr_done = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        rd_addr_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic run_cmd(input logic [9:0] x1, input logic [9:0] x2, input logic [9:0] y1,
                           input logic [9:0] y2, input logic [11:0] color, input logic mode,
                           input logic bk, input bit poke_busy);
        int unsigned d0;
        bit seen;
        clear_logs();
        d0 = done_cnt;
        @(negedge clk);
        cmd_x1 = x1; cmd_x2 = x2; cmd_y1 = y1; cmd_y2 = y2;
        cmd_color = color; cmd_mode = mode; bank = bk; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        if (poke_busy) begin
            cmd_x1 = 10'd0; cmd_x2 = 10'd0; cmd_y1 = 10'd0; cmd_y2 = 10'd0;
            cmd_color = 12'h0AA; cmd_mode = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - d0, 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_logs(input int unsigned n_rd);
        check("rd_count", rd_addr_log.size(), n_rd);
        check("wr_count", wr_addr_log.size(), exp_a.size());
        foreach (exp_a[i]) begin
            if (i < wr_addr_log.size()) begin
                check("wr_addr", 32'(wr_addr_log[i]), 32'(exp_a[i]));
                check("wr_data", 32'(wr_data_log[i]), 32'(exp_d[i]));
            end
        end
        exp_a.delete();
        exp_d.delete();
    endtask

    initial begin
        int unsigned d0;
        bit seen;
        rst = 1'b1; start = 1'b0; bank = 1'b0;
        cmd_x1 = '0; cmd_x2 = '0; cmd_y1 = '0; cmd_y2 = '0; cmd_color = '0; cmd_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_reqs", 32'({rd_req, wr_req}), 32'd0);
        check("rst_addr", 32'(wr_addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full words only, plus a start pulsed while busy that must be ignored.
        exp_a = '{20'hE01, 20'hE02};
        exp_d = '{24'hF00F00, 24'hF00F00};
        run_cmd(10'd2, 10'd5, 10'd7, 10'd7, 12'hF00, 1'b0, 1'b0, 1'b1);
        check_logs(0);

        // Partial words at both ends need read-merge.
        rd_data_q = '{24'hABC123, 24'h456DEF};
        exp_a = '{20'h001, 20'h002};
        exp_d = '{24'hABCF00, 24'hF00DEF};
        run_cmd(10'd3, 10'd4, 10'd0, 10'd0, 12'hF00, 1'b0, 1'b0, 1'b0);
        check("rd_addr0", 32'(rd_addr_log.size() > 0 ? rd_addr_log[0] : 20'hFFFFF), 32'h001);
        check_logs(2);

        // XOR on slot 0 only.
        rd_data_q = '{24'h123456};
        exp_a = '{20'h000};
        exp_d = '{24'hEDC456};
        run_cmd(10'd0, 10'd0, 10'd0, 10'd0, 12'hFFF, 1'b1, 1'b0, 1'b0);
        check_logs(1);

        // Multi-line, full-word opaque.
        exp_a = '{20'h1400, 20'h1600, 20'h1800};
        exp_d = '{24'h5A35A3, 24'h5A35A3, 24'h5A35A3};
        run_cmd(10'd0, 10'd1, 10'd10, 10'd12, 12'h5A3, 1'b0, 1'b0, 1'b0);
        check_logs(0);

        // Empty span: done two cycles after start, no requests.
        clear_logs();
        d0 = done_cnt;
        @(negedge clk);
        cmd_x1 = 10'd6; cmd_x2 = 10'd5; cmd_y1 = 10'd0; cmd_y2 = 10'd0; cmd_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_done_c1", 32'(done), 32'd0);
        check("empty_busy_c1", 32'(busy), 32'd1);
        @(negedge clk);
        check("empty_done_c2", 32'(done), 32'd1);
        @(negedge clk);
        check("empty_done_c3", 32'(done), 32'd0);
        check("empty_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("empty_done_once", done_cnt - d0, 32'd1);
        check("empty_no_req", rd_addr_log.size() + wr_addr_log.size(), 32'd0);

        // Reset while waiting for read data; the late valid lands in IDLE.
        clear_logs();
        rd_data_q.delete();
        rd_lat = 8;
        d0 = done_cnt;
        @(negedge clk);
        cmd_x1 = 10'd0; cmd_x2 = 10'd0; cmd_y1 = 10'd3; cmd_y2 = 10'd3;
        cmd_color = 12'h111; cmd_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rd_req) seen = 1'b1;
            else @(negedge clk);
        end
        check("rst_test_read_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_reqs", 32'({rd_req, wr_req}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_no_write", wr_addr_log.size(), 32'd0);
        check("midrst_still_idle", 32'(busy), 32'd0);
        rd_lat = 2;

        rd_data_q = '{24'h123456};
        exp_a = '{20'h000};
        exp_d = '{24'h123BA9};
        run_cmd(10'd1, 10'd1, 10'd0, 10'd0, 12'hFFF, 1'b1, 1'b0, 1'b0);
        check_logs(1);

        // Maximum coordinates on bank 1: must end without counter wrap.
        exp_a = '{20'hFFFFF};
        exp_d = '{24'h777777};
        run_cmd(10'd1022, 10'd1023, 10'd1023, 10'd1023, 12'h777, 1'b0, 1'b1, 1'b0);
        check_logs(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/renderer_rect_fill_multi.md
RENDERER_RECT_FILL_MULTI -- requirements
Module: renderer_rect_fill_multi

Interface
REQ-001 SHALL have parameter COLOR_W, default 4, bits per colour channel; pixel width PIX_W = 3*COLOR_W, ordered {R,G,B}.
REQ-002 SHALL have parameter PIX_PER_WORD, default 2, pixels per VRAM word (power of two, 1..8); word width WORD_W = PIX_PER_WORD*PIX_W.
REQ-003 SHALL have parameters X_W, default 10, and Y_W, default 10, the coordinate widths; column width COL_W = X_W - log2(PIX_PER_WORD); address width 1+Y_W+COL_W (20 at defaults).
REQ-004 i_master_clk  in  1  sole clock, all state on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_cmd_x1, i_cmd_x2  in  X_W  inclusive horizontal pixel span.
REQ-007 i_cmd_y1, i_cmd_y2  in  Y_W  inclusive line span.
REQ-008 i_cmd_color  in  PIX_W  fill colour.
REQ-009 i_cmd_mode  in  1  0 = opaque fill, 1 = XOR with existing pixels.
REQ-010 i_process_start  in  1  one-cycle command strobe.
REQ-011 o_process_done  out  1  one-cycle completion pulse.
REQ-012 o_busy  out  1  high from the cycle after an accepted start until the done pulse.
REQ-013 i_buffer_bank  in  1  target bank, sampled at start.
REQ-014 o_vram_read_address, o_vram_write_address  out  1+Y_W+COL_W  {bank, line, column}.
REQ-015 o_vram_read_request  out  1; i_vram_read_data  in  WORD_W; i_vram_read_data_valid  in  1.
REQ-016 o_vram_write_request  out  1; o_vram_write_data  out  WORD_W; i_vram_write_done  in  1.

Function
REQ-017 Start while idle SHALL latch all cmd inputs and bank; start while busy SHALL be ignored.
REQ-018 Pixel x SHALL occupy slot x mod PIX_PER_WORD of word column x/PIX_PER_WORD; slot 0 in the most significant PIX_W bits.
REQ-019 Lines SHALL be processed y1 ascending to y2; within a line, columns x1/PPW ascending to x2/PPW.
REQ-020 States SHALL be IDLE, LINE_START, READ, READ_WAIT, WRITE, WRITE_WAIT, NEXT, DONE.
REQ-021 A word SHALL be read first (READ) iff mode is XOR or its slot mask is not all-ones; otherwise LINE_START/NEXT go directly to WRITE.
REQ-022 Read and write requests SHALL each be exactly one cycle high, entering READ/WRITE; addresses and write data SHALL be stable until the matching valid/done.
REQ-023 READ_WAIT SHALL hold until i_vram_read_data_valid; WRITE_WAIT until i_vram_write_done; no cycle limit.
REQ-024 Write data per slot: unmasked slot = read data; masked slot = colour (opaque) or read pixel XOR colour (XOR).
REQ-025 NEXT SHALL advance column, or on last column of a line advance line and restart at first column, or after y2 enter DONE.
REQ-026 o_process_done SHALL pulse in DONE, exactly once per accepted command, the cycle after the final write_done is sampled; state then returns to IDLE.
REQ-027 If x1>x2 or y1>y2, SHALL issue no VRAM request and pulse done two cycles after start.
REQ-028 Valid/done inputs arriving outside their wait state SHALL be ignored.
REQ-029 Coordinates at maximum (x2 = 2^X_W-1, y2 = 2^Y_W-1) SHALL terminate without counter wrap.

Reset
REQ-030 Reset SHALL force IDLE, o_busy, o_process_done, both requests to 0; addresses and write data to 0.
REQ-031 Reset mid-command SHALL abandon it with no done pulse; first start after release SHALL be accepted normally.

Structure
REQ-032 Mode encodings and state encoding SHALL live in shared package renderer_pkg.
REQ-033 Slot-mask generation and read-merge/XOR SHALL be one combinational sub-module renderer_pixel_merge.

Verification (defaults, bank 0)
REQ-034 Opaque x 2..5, y 7, colour F00 -> writes only, col 1 then 2, addr {0,7,1},{0,7,2}, data F00F00; one done.
REQ-035 Opaque x 3..4, y 0, colour F00; reads return ABC123, 456DEF -> writes ABCF00 to col 1, F00DEF to col 2.
REQ-036 XOR x 0..0, colour FFF; read returns 123456 -> write EDC456.
REQ-037 Opaque x 0..1, y 10..12 -> three writes to lines 10,11,12 col 0, no reads, single done.
REQ-038 x1=6, x2=5 -> no requests, done two cycles after start; separately, reset during READ_WAIT -> requests low, no done, next command completes.
